// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result bundle for the serial magnitude comparator.
// The master modport is the operand source and flag consumer. The slave modport is the comparator.
interface serial_magnitude_comparator_if #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
);
  localparam int W = 3 * NUM_DIGITS;

  logic             start_valid;
  logic             start_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             signed_mode;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic             grth;
  logic             lsth;
  logic             eq;
  logic [CNT_W-1:0] digits_used;

  modport master (
    output start_valid, a, b, signed_mode, abort, res_ready,
    input  start_ready, res_valid, grth, lsth, eq, digits_used
  );

  modport slave (
    input  start_valid, a, b, signed_mode, abort, res_ready,
    output start_ready, res_valid, grth, lsth, eq, digits_used
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Compares wide operands one 3-bit digit per cycle, starting at the MSB digit.
// It stops at the first unequal digit and reports one-hot flags and the number of digits examined.
module serial_magnitude_comparator #(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int W     = 3 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             signed_q, signed_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             start_ready_q, start_ready_d;
  logic             res_valid_q, res_valid_d;
  logic             grth_q, grth_d;
  logic             lsth_q, lsth_d;
  logic             eq_q, eq_d;
  logic [CNT_W-1:0] digits_used_q, digits_used_d;
  logic [2:0]       dig_a, dig_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      signed_q      <= 1'b0;
      idx_q         <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      grth_q        <= 1'b0;
      lsth_q        <= 1'b0;
      eq_q          <= 1'b0;
      digits_used_q <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      signed_q      <= signed_d;
      idx_q         <= idx_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
      grth_q        <= grth_d;
      lsth_q        <= lsth_d;
      eq_q          <= eq_d;
      digits_used_q <= digits_used_d;
    end
  end

  // In signed mode, the MSB digit is biased by flipping its sign bit.
  // This lets a single unsigned compare handle both modes.
  always_comb begin
    dig_a = a_q[3*int'(idx_q) +: 3];
    dig_b = b_q[3*int'(idx_q) +: 3];
    if (signed_q && (int'(idx_q) == NUM_DIGITS - 1)) begin
      dig_a[2] = ~dig_a[2];
      dig_b[2] = ~dig_b[2];
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    signed_d      = signed_q;
    idx_d         = idx_q;
    grth_d        = grth_q;
    lsth_d        = lsth_q;
    eq_d          = eq_q;
    digits_used_d = digits_used_q;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          signed_d = bus.signed_mode;
          idx_d    = IDX_W'(NUM_DIGITS - 1);
          state_d  = CMP;
        end
      end
      CMP: begin
        if (bus.abort) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (dig_a > dig_b) begin
          grth_d        = 1'b1;
          digits_used_d = CNT_W'(NUM_DIGITS - int'(idx_q));
          state_d       = DONE;
        end else if (dig_a < dig_b) begin
          lsth_d        = 1'b1;
          digits_used_d = CNT_W'(NUM_DIGITS - int'(idx_q));
          state_d       = DONE;
        end else if (idx_q == '0) begin
          eq_d          = 1'b1;
          digits_used_d = CNT_W'(NUM_DIGITS);
          state_d       = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          grth_d        = 1'b0;
          lsth_d        = 1'b0;
          eq_d          = 1'b0;
          digits_used_d = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.grth        = grth_q;
  assign bus.lsth        = lsth_q;
  assign bus.eq          = eq_q;
  assign bus.digits_used = digits_used_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator with NUM_DIGITS=4.
module tb_serial_magnitude_comparator;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  serial_magnitude_comparator_if #(.NUM_DIGITS(4)) bus_if ();

  serial_magnitude_comparator #(.NUM_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair, then scrambles the operand inputs.
  // Checks the latency, the flags and the digit count. It optionally takes the result afterwards.
  task automatic applyStimulus(input string tag, input logic [11:0] av, input logic [11:0] bv,
                               input logic sm, input logic eg, input logic el, input logic ee,
                               input int ek, input bit take);
    int cycles;
    checkOutput({tag, "_ready_before"}, bus_if.start_ready, 1);
    bus_if.start_valid = 1'b1;
    bus_if.a           = av;
    bus_if.b           = bv;
    bus_if.signed_mode = sm;
    step();
    bus_if.start_valid = 1'b0;
    bus_if.a           = 12'($urandom);
    bus_if.b           = 12'($urandom);
    bus_if.signed_mode = ~sm;
    checkOutput({tag, "_ready_busy"}, bus_if.start_ready, 0);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!bus_if.res_valid && cycles < 20);
    checkOutput({tag, "_latency"}, cycles, ek);
    checkOutput({tag, "_grth"}, bus_if.grth, eg);
    checkOutput({tag, "_lsth"}, bus_if.lsth, el);
    checkOutput({tag, "_eq"}, bus_if.eq, ee);
    checkOutput({tag, "_digits"}, bus_if.digits_used, ek);
    if (take) begin
      bus_if.res_ready = 1'b1;
      step();
      bus_if.res_ready = 1'b0;
      checkOutput({tag, "_valid_after"}, bus_if.res_valid, 0);
      checkOutput({tag, "_flags_after"}, {bus_if.grth, bus_if.lsth, bus_if.eq}, 0);
      checkOutput({tag, "_ready_after"}, bus_if.start_ready, 1);
    end
  endtask

  // Starts a=1234 b=1235 and returns during the second compare cycle.
  task automatic startAndHold();
    bus_if.start_valid = 1'b1;
    bus_if.a           = 12'o1234;
    bus_if.b           = 12'o1235;
    bus_if.signed_mode = 1'b0;
    step();
    bus_if.start_valid = 1'b0;
    step();
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b1;
    bus_if.start_valid = 1'b0;
    bus_if.a           = '0;
    bus_if.b           = '0;
    bus_if.signed_mode = 1'b0;
    bus_if.abort       = 1'b0;
    bus_if.res_ready   = 1'b0;
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_start_ready", bus_if.start_ready, 1);
    checkOutput("reset_res_valid", bus_if.res_valid, 0);
    checkOutput("reset_flags", {bus_if.grth, bus_if.lsth, bus_if.eq}, 0);
    checkOutput("reset_digits", bus_if.digits_used, 0);

    applyStimulus("t1_gt_msb", 12'o7000, 12'o6777, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("t2_lt_lsd", 12'o0443, 12'o0444, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1);
    applyStimulus("t3_eq", 12'o5252, 12'o5252, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    applyStimulus("t3_eq_zero", 12'o0000, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b1);
    applyStimulus("t4_signed", 12'o7000, 12'o0001, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    applyStimulus("t4_unsigned", 12'o7000, 12'o0001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("signed_3_vs_m4", 12'o3000, 12'o4000, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    applyStimulus("signed_lower_unsigned", 12'o7100, 12'o7070, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1);
    applyStimulus("signed_eq_neg", 12'o4321, 12'o4321, 1'b1, 1'b0, 1'b0, 1'b1, 4, 1'b1);

    // A result held under backpressure, with a competing start_valid that must not be taken.
    applyStimulus("t5_bp", 12'o7000, 12'o6777, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    bus_if.start_valid = 1'b1;
    bus_if.a           = 12'o0000;
    bus_if.b           = 12'o0001;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("t5_hold_valid", bus_if.res_valid, 1);
      checkOutput("t5_hold_grth", bus_if.grth, 1);
      checkOutput("t5_hold_digits", bus_if.digits_used, 1);
      checkOutput("t5_hold_ready", bus_if.start_ready, 0);
    end
    bus_if.res_ready = 1'b1;
    step();
    bus_if.res_ready   = 1'b0;
    bus_if.start_valid = 1'b0;
    checkOutput("t5_release_valid", bus_if.res_valid, 0);
    checkOutput("t5_release_flags", {bus_if.grth, bus_if.lsth, bus_if.eq}, 0);
    checkOutput("t5_release_ready", bus_if.start_ready, 1);
    step();
    checkOutput("t5_no_accept_in_done", bus_if.start_ready, 1);

    startAndHold();
    bus_if.abort = 1'b1;
    step();
    bus_if.abort = 1'b0;
    checkOutput("t6_abort_ready", bus_if.start_ready, 1);
    checkOutput("t6_abort_valid", bus_if.res_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("t6_abort_no_result", {bus_if.res_valid, bus_if.grth, bus_if.lsth, bus_if.eq}, 0);
    end

    startAndHold();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t6_rst_ready", bus_if.start_ready, 1);
    checkOutput("t6_rst_valid", bus_if.res_valid, 0);
    checkOutput("t6_rst_flags", {bus_if.grth, bus_if.lsth, bus_if.eq}, 0);
    checkOutput("t6_rst_digits", bus_if.digits_used, 0);
    step();
    checkOutput("t6_rst_no_result", bus_if.res_valid, 0);

    applyStimulus("t6_fresh", 12'o1234, 12'o1235, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
